vga_timing_gen: RTL

//  Generates the VGA raster timing that drives the hsync/vsync/red/green/blue pins of top.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Divides clk down to a pixel clock enable, runs the horizontal/vertical counters and emits
// registered sync, active-video, coordinates, line/frame strobes and optional test-pattern rgb.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars on red/green/blue).
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             SP      = (SYNC_POL != 0);

  // Sync level for a counter value inside [lo, hi).
  function automatic logic sync_lvl(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return ((v >= lo) && (v < hi)) ? SP : ~SP;
  endfunction

  logic [DIV_W-1:0] div;
  logic             started;   // blocks pix_ce until the first edge after reset (matters for CLK_DIV=1)
  logic             x_wrap, y_wrap, act_nx;
  logic [CNT_W-1:0] x_nx, y_nx;

  assign pix_ce = en & started & (div == DIV_MAX);

  // Next raster position and its visible-area decode.
  always_comb begin
    x_wrap = (x == H_LAST);
    y_wrap = (y == V_LAST);
    x_nx   = x_wrap ? '0 : x + 1'b1;
    y_nx   = y;
    if (x_wrap) y_nx = y_wrap ? '0 : y + 1'b1;
    act_nx = (x_nx < H_VIS) && (y_nx < V_VIS);
  end

  // Divider, counters and registered decode of the next position; en=0 holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div         <= '0;
      started     <= 1'b0;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= ~SP;
      vsync       <= ~SP;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      started     <= 1'b1;
      if (en) div <= (div == DIV_MAX) ? '0 : div + 1'b1;
      line_start  <= pix_ce & x_wrap;
      frame_start <= pix_ce & x_wrap & y_wrap;
      if (pix_ce) begin
        x      <= x_nx;
        y      <= y_nx;
        active <= act_nx;
        hsync  <= sync_lvl(x_nx, HS_BEG, HS_END);
        vsync  <= sync_lvl(y_nx, VS_BEG, VS_END);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W+3)'(H_ACTIVE);

  logic [CNT_W+2:0] x8;
  logic [2:0]       bar;

  // Bar index of the next pixel: x*8/H_ACTIVE.
  always_comb begin
    x8  = {x_nx, 3'b000};
    bar = 3'(x8 / BAR_DIV);
  end

  // Colour bars registered alongside x/y so rgb describes the same pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (pix_ce) begin
      red   <= (act_nx && bar[0]) ? 4'hF : 4'h0;
      green <= (act_nx && bar[1]) ? 4'hF : 4'h0;
      blue  <= (act_nx && bar[2]) ? 4'hF : 4'h0;
    end
  end
`else
  assign red   = 4'h0;
  assign green = 4'h0;
  assign blue  = 4'h0;
`endif

endmodule
